// File: rtl/servo_bank_if.sv
// servo_bank_if: valid/ready position command port for servo_bank
interface servo_bank_if #(
   parameter int CW    = 2,
   parameter int POS_W = 8
);
   logic             pos_valid;
   logic             pos_ready;
   logic [CW-1:0]    pos_chan;
   logic [POS_W-1:0] pos_data;
   modport master (output pos_valid, pos_chan, pos_data, input pos_ready);
   modport slave  (input pos_valid, pos_chan, pos_data, output pos_ready);
endinterface

// File: rtl/servo_bank.sv
// servo_bank: multi-channel slew-limited servo PWM driver sharing one frame counter
module servo_bank #(
   parameter int CLK_FREQ  = 25_000_000,
   parameter int CHANNELS  = 4,
   parameter int PERIOD    = 500_000,
   parameter int PULSE_MIN = 25_000,
   parameter int PULSE_MAX = 50_000,
   parameter int POS_W     = 8,
   parameter int STEP      = 1000,
   parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   servo_bank_if.slave         pos,
   output logic [CHANNELS-1:0] servo_out,
   output logic                frame_start,
   output logic [CHANNELS-1:0] settled,
   output logic                err
);
   localparam int RANGE = PULSE_MAX - PULSE_MIN;
   localparam int WW    = $clog2(PULSE_MAX + 1);
   localparam int PW    = POS_W + $clog2(RANGE + 1);
   localparam int DEN   = (2 ** POS_W) - 1;
   localparam int CNTW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   if (CLK_FREQ < 1 || PULSE_MIN > PULSE_MAX || PULSE_MAX >= PERIOD || CW < $clog2(CHANNELS)) begin : g_bad
      $error("servo_bank: invalid parameters");
   end

   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic                pos_ready_q;
   logic                err_q, err_d;
   logic                fs_q, fs_d;
   logic [CHANNELS-1:0] servo_q, servo_d;
   logic [WW-1:0]       cur_q [CHANNELS];
   logic [WW-1:0]       cur_d [CHANNELS];
   logic [WW-1:0]       tgt_q [CHANNELS];
   logic [WW-1:0]       tgt_d [CHANNELS];
   logic [PW-1:0]       prod;
   logic [WW-1:0]       map_w;
   logic                wr;

   function automatic logic [WW-1:0] slew(input logic [WW-1:0] c, input logic [WW-1:0] t);
      logic [WW-1:0] d;
      d = (t > c) ? t - c : c - t;
      return (STEP == 0 || 32'(d) <= STEP) ? t : (t > c) ? c + WW'(STEP) : c - WW'(STEP);
   endfunction

   assign prod  = PW'(pos.pos_data) * PW'(RANGE);
   assign map_w = WW'(PULSE_MIN) + WW'(prod / PW'(DEN));
   assign wr    = pos.pos_valid && pos_ready_q;

   always_comb begin
      cnt_d = (pos_ready_q && cnt_q != CNTW'(PERIOD - 1)) ? cnt_q + 1'b1 : '0;
      fs_d  = cnt_d == '0;
      err_d = err_q | (wr && 32'(pos.pos_chan) >= CHANNELS);
      for (int i = 0; i < CHANNELS; i++) begin
         tgt_d[i]   = (wr && 32'(pos.pos_chan) == i) ? map_w : tgt_q[i];
         cur_d[i]   = fs_d ? slew(cur_q[i], tgt_q[i]) : cur_q[i];
         servo_d[i] = 32'(cnt_d) < 32'(cur_d[i]);
         settled[i] = cur_q[i] == tgt_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         pos_ready_q <= 1'b0;
         err_q       <= 1'b0;
         fs_q        <= 1'b0;
         servo_q     <= '0;
         cur_q       <= '{default: WW'(PULSE_MIN)};
         tgt_q       <= '{default: WW'(PULSE_MIN)};
      end else begin
         cnt_q       <= cnt_d;
         pos_ready_q <= 1'b1;
         err_q       <= err_d;
         fs_q        <= fs_d;
         servo_q     <= servo_d;
         cur_q       <= cur_d;
         tgt_q       <= tgt_d;
      end
   end

   assign pos.pos_ready = pos_ready_q;
   assign servo_out     = servo_q;
   assign frame_start   = fs_q;
   assign err           = err_q;
endmodule

// File: tb/tb_servo_bank.sv
// tb_servo_bank: directed and random checks of servo_bank (STEP=3 and STEP=0) against a frame-level model
module tb_servo_bank;
   localparam int CH = 4, P = 100, PMIN = 10, PMAX = 20, PW = 4, CW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic v = 1'b0;
   logic [CW-1:0] c = '0;
   logic [PW-1:0] dt = '0;
   logic [CH-1:0] so3, so0, st3, st0;
   logic fs3, fs0, er3, er0;

   always #5 clk = ~clk;

   servo_bank_if #(.CW(CW), .POS_W(PW)) b3 ();
   servo_bank_if #(.CW(CW), .POS_W(PW)) b0 ();
   assign b3.pos_valid = v;
   assign b3.pos_chan  = c;
   assign b3.pos_data  = dt;
   assign b0.pos_valid = v;
   assign b0.pos_chan  = c;
   assign b0.pos_data  = dt;

   servo_bank #(.CHANNELS(CH), .PERIOD(P), .PULSE_MIN(PMIN), .PULSE_MAX(PMAX), .POS_W(PW), .STEP(3), .CW(CW)) dut3 (
      .clk(clk), .rst_n(rst_n), .pos(b3), .servo_out(so3), .frame_start(fs3), .settled(st3), .err(er3));
   servo_bank #(.CHANNELS(CH), .PERIOD(P), .PULSE_MIN(PMIN), .PULSE_MAX(PMAX), .POS_W(PW), .STEP(0), .CW(CW)) dut0 (
      .clk(clk), .rst_n(rst_n), .pos(b0), .servo_out(so0), .frame_start(fs0), .settled(st0), .err(er0));

   int vecs = 0, fails = 0;
   int stp [2] = '{3, 0};
   int mcnt = 0, nfs = 0;
   bit mrun = 0, mrdy = 0;
   bit merr [2];
   int cur [2][CH];
   int tgt [2][CH];
   int hi [2][CH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int map(input int p);
      return PMIN + p * (PMAX - PMIN) / ((1 << PW) - 1);
   endfunction

   function automatic int approach(input int cc, input int t, input int s);
      int diff;
      diff = (t > cc) ? t - cc : cc - t;
      if (s == 0 || diff <= s) return t;
      return (t > cc) ? cc + s : cc - s;
   endfunction

   task automatic model_edge();
      if (!rst_n) begin
         mrun = 0; mrdy = 0; mcnt = 0;
         for (int d = 0; d < 2; d++) begin
            merr[d] = 0;
            for (int i = 0; i < CH; i++) begin cur[d][i] = PMIN; tgt[d][i] = PMIN; end
         end
      end else begin
         mcnt = mrun ? (mcnt + 1) % P : 0;
         mrun = 1;
         for (int d = 0; d < 2; d++) begin
            if (mcnt == 0)
               for (int i = 0; i < CH; i++) cur[d][i] = approach(cur[d][i], tgt[d][i], stp[d]);
            if (v && mrdy) begin
               if (int'(c) >= CH) merr[d] = 1;
               else tgt[d][c] = map(int'(dt));
            end
         end
         mrdy = 1;
      end
   endtask

   task automatic check_dut(input int d, input logic [CH-1:0] so, input logic [CH-1:0] st,
                            input logic fs, input logic er, input logic rdy);
      logic [CH-1:0] eso, est;
      string s;
      s = d == 0 ? "_s3" : "_s0";
      for (int i = 0; i < CH; i++) begin
         eso[i] = mrun && mcnt < cur[d][i];
         est[i] = cur[d][i] == tgt[d][i];
         if (!rst_n || (mrun && mcnt == 0)) hi[d][i] = 0;
         hi[d][i] += int'(so[i]);
      end
      chk({"servo_out", s}, 32'(so), 32'(eso));
      chk({"settled", s}, 32'(st), 32'(est));
      chk({"frame_start", s}, 32'(fs), 32'(mrun && mcnt == 0));
      chk({"err", s}, 32'(er), 32'(merr[d]));
      chk({"pos_ready", s}, 32'(rdy), 32'(mrdy));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_dut(0, so3, st3, fs3, er3, b3.pos_ready);
      check_dut(1, so0, st0, fs0, er0, b0.pos_ready);
      nfs += int'(fs3);
   endtask

   task automatic frame_end();
      int n;
      n = 0;
      do begin tick(); n++; end while (mcnt != P - 1 && n < 2 * P);
   endtask

   task automatic wr(input int ch, input int data);
      v = 1'b1; c = CW'(ch); dt = PW'(data);
      tick();
      v = 1'b0;
   endtask

   task automatic widths(input string tag, input int d, input int w0, input int w1, input int w2, input int w3);
      chk({tag, "_c0"}, 32'(hi[d][0]), 32'(w0));
      chk({tag, "_c1"}, 32'(hi[d][1]), 32'(w1));
      chk({tag, "_c2"}, 32'(hi[d][2]), 32'(w2));
      chk({tag, "_c3"}, 32'(hi[d][3]), 32'(w3));
   endtask

   initial begin
      int exp2 [5];
      exp2 = '{13, 16, 19, 20, 20};
      repeat (3) tick();
      rst_n = 1'b1;
      nfs = 0;
      repeat (300) tick();
      chk("frames3", 32'(nfs), 32'd3);
      widths("w_init_s3", 0, 10, 10, 10, 10);
      chk("settled_init", 32'(st3), 32'hf);
      idle_mid: repeat (50) tick();
      wr(2, 15);
      frame_end();
      widths("w_pre_s3", 0, 10, 10, 10, 10);
      for (int k = 0; k < 5; k++) begin
         frame_end();
         chk("w_ch2_s3", 32'(hi[0][2]), 32'(exp2[k]));
         chk("settled2_s3", 32'(st3[2]), 32'(exp2[k] == 20));
         chk("w_ch0_s3", 32'(hi[0][0]), 32'd10);
         chk("w_ch2_s0", 32'(hi[1][2]), 32'd20);
      end
      repeat (20) tick();
      wr(1, 7);
      frame_end();
      frame_end();
      chk("w_ch1a_s3", 32'(hi[0][1]), 32'd13);
      frame_end();
      chk("w_ch1b_s3", 32'(hi[0][1]), 32'd14);
      chk("w_ch1_s0", 32'(hi[1][1]), 32'd14);
      repeat (30) tick();
      wr(3, 15);
      wr(3, 0);
      frame_end();
      frame_end();
      chk("w_ch3_s0", 32'(hi[1][3]), 32'd10);
      chk("w_ch3_s3", 32'(hi[0][3]), 32'd10);
      chk("settled3_s0", 32'(st0[3]), 32'd1);
      repeat (10) tick();
      wr(5, 3);
      chk("err_set_s3", 32'(er3), 32'd1);
      chk("err_set_s0", 32'(er0), 32'd1);
      frame_end();
      frame_end();
      widths("w_err_s3", 0, 10, 14, 20, 10);
      widths("w_err_s0", 1, 10, 14, 20, 10);
      chk("err_sticky", 32'(er3), 32'd1);
      wr(0, 15);
      chk("bnd_fs", 32'(fs3), 32'd1);
      frame_end();
      chk("w_bnd0_s3", 32'(hi[0][0]), 32'd10);
      chk("w_bnd0_s0", 32'(hi[1][0]), 32'd10);
      frame_end();
      chk("w_bnd1_s3", 32'(hi[0][0]), 32'd13);
      chk("w_bnd1_s0", 32'(hi[1][0]), 32'd20);
      repeat (6) tick();
      chk("pre_rst_out", 32'(so3), 32'hf);
      rst_n = 1'b0;
      #1;
      chk("async_so_s3", 32'(so3), 32'd0);
      chk("async_so_s0", 32'(so0), 32'd0);
      chk("async_fs", 32'(fs3), 32'd0);
      chk("async_rdy", 32'(b3.pos_ready), 32'd0);
      chk("async_err", 32'(er3), 32'd0);
      chk("async_settled", 32'(st3), 32'hf);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (P) tick();
      widths("w_rst_s3", 0, 10, 10, 10, 10);
      widths("w_rst_s0", 1, 10, 10, 10, 10);
      chk("err_clr", 32'(er3), 32'd0);
      repeat (3000) begin
         v  = $urandom_range(0, 7) == 0;
         c  = ($urandom_range(0, 19) == 0) ? CW'(5) : CW'($urandom_range(0, CH - 1));
         dt = PW'($urandom_range(0, 15));
         tick();
      end
      v = 1'b0;
      repeat (2 * P) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule
